// File: rtl/instr_loader.sv
// instr_loader: front-end stage for cpu_core.
// Synchronises, debounces and edge-detects a raw push-button, then assembles
// two button-strobed switch bytes into {opcode[3:0], instr[11:0]}.
// Optional feature macro: INSTR_LOADER_DEBOUNCE_EN.
//   Defined   : counter-based debouncer (DEBOUNCE_CYCLES stable cycles).
//   Undefined : btn_db is btn_s delayed by one register, no counter.
module instr_loader #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data_in,
    input  logic        btn,
    output logic [3:0]  opcode,
    output logic [11:0] instr,
    output logic        inst_done,
    output logic        btn_edge,
    output logic        loading
);

    // A debounce window below two cycles could not reject anything.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("instr_loader: DEBOUNCE_CYCLES must be at least 2");
    end

    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) + 1 : 1;
    localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        HAVE_HI = 1'b1
    } state_t;

    logic [1:0]     sync_reg;
    logic           btn_s;
    logic           btn_db_reg;
    logic           btn_db_d_reg;
    logic           btn_edge_reg;

    state_t         state_reg, state_next;
    logic [7:0]     hi_reg, hi_next;
    logic [TCW-1:0] to_cnt_reg, to_cnt_next;
    logic [3:0]     opcode_reg, opcode_next;
    logic [11:0]    instr_reg, instr_next;
    logic           done_reg, done_next;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_reg <= 2'b00;
        else        sync_reg <= {sync_reg[0], btn};
    end

    assign btn_s = sync_reg[1];

`ifdef INSTR_LOADER_DEBOUNCE_EN
    localparam int DCW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);

    logic [DCW-1:0] db_cnt_reg;

    // Debouncer: btn_db follows btn_s only after it has differed long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_reg <= '0;
            btn_db_reg <= 1'b0;
        end else if (btn_s == btn_db_reg) begin
            db_cnt_reg <= '0;
        end else if (db_cnt_reg == DB_LAST) begin
            btn_db_reg <= btn_s;
            db_cnt_reg <= '0;
        end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
        end
    end
`else
    // Clean-stimulus build: one register stage in place of the debouncer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) btn_db_reg <= 1'b0;
        else        btn_db_reg <= btn_s;
    end
`endif

    // Registered rising-edge detector on the debounced button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db_d_reg <= 1'b0;
            btn_edge_reg <= 1'b0;
        end else begin
            btn_db_d_reg <= btn_db_reg;
            btn_edge_reg <= btn_db_reg & ~btn_db_d_reg;
        end
    end

    // Loader state and instruction output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            hi_reg     <= '0;
            to_cnt_reg <= '0;
            opcode_reg <= '0;
            instr_reg  <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            hi_reg     <= hi_next;
            to_cnt_reg <= to_cnt_next;
            opcode_reg <= opcode_next;
            instr_reg  <= instr_next;
            done_reg   <= done_next;
        end
    end

    // Next-state logic: a press always beats the timeout in HAVE_HI.
    always_comb begin
        state_next  = state_reg;
        hi_next     = hi_reg;
        to_cnt_next = to_cnt_reg;
        opcode_next = opcode_reg;
        instr_next  = instr_reg;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (btn_edge_reg) begin
                    hi_next     = data_in;
                    to_cnt_next = '0;
                    state_next  = HAVE_HI;
                end
            end
            HAVE_HI: begin
                if (btn_edge_reg) begin
                    {opcode_next, instr_next} = {hi_reg, data_in};
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (to_cnt_reg == TO_LAST)) begin
                    hi_next     = '0;
                    to_cnt_next = '0;
                    state_next  = IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign opcode    = opcode_reg;
    assign instr     = instr_reg;
    assign inst_done = done_reg;
    assign btn_edge  = btn_edge_reg;
    assign loading   = (state_reg == HAVE_HI);

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader (DEBOUNCE_CYCLES=16, TIMEOUT_CYCLES=64).
module tb_instr_loader;

    localparam int DB = 16;
    localparam int TO = 64;
`ifdef INSTR_LOADER_DEBOUNCE_EN
    localparam int LAT = DB + 2;
`else
    localparam int LAT = 3;
`endif
    localparam int HOLD = LAT + 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data_in;
    logic        btn;
    logic [3:0]  opcode;
    logic [11:0] instr;
    logic        inst_done;
    logic        btn_edge;
    logic        loading;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_edge = 0, n_done = 0;
    int edge_cyc = 0, done_cyc = 0, rise_cyc = 0, fall_cyc = 0;
    bit load_prev = 1'b0;
    int c, c1, c2, c_last, e0, d0;

    instr_loader #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .btn(btn),
        .opcode(opcode), .instr(instr), .inst_done(inst_done),
        .btn_edge(btn_edge), .loading(loading)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (btn_edge === 1'b1) begin n_edge++; edge_cyc = cyc; end
        if (inst_done === 1'b1) begin n_done++; done_cyc = cyc; end
        if ((loading === 1'b1) && !load_prev) rise_cyc = cyc;
        if ((loading !== 1'b1) && load_prev) fall_cyc = cyc;
        load_prev = (loading === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Clean press: hold long enough to debounce, then release long enough to debounce.
    task automatic press(input logic [7:0] d, output int start);
        data_in = d;
        btn = 1'b1;
        start = cyc;
        tick(HOLD);
        btn = 1'b0;
        tick(HOLD);
    endtask

    initial begin
        rst_n = 1'b1; btn = 1'b0; data_in = 8'h00;
        // Asynchronous reset mid-cycle
        #3 rst_n = 1'b0;
        #1;
        chk("rst_opcode", opcode, 0);
        chk("rst_instr", instr, 0);
        chk("rst_inst_done", inst_done, 0);
        chk("rst_btn_edge", btn_edge, 0);
        chk("rst_loading", loading, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick(2);

        // Clean two-byte load 0xA5, 0x3C
        e0 = n_edge; d0 = n_done;
        press(8'hA5, c);
        $display("press data=a5 edge_cyc=%0d", edge_cyc);
        chk("load1_edge_cnt", n_edge - e0, 1);
        chk("load1_edge_cyc", edge_cyc, c + 1 + LAT);
        chk("load1_loading", loading, 1);
        chk("load1_no_done", n_done - d0, 0);
        press(8'h3C, c);
        $display("press data=3c opcode=%0h instr=%0h", opcode, instr);
        chk("load2_edge_cnt", n_edge - e0, 2);
        chk("load2_edge_cyc", edge_cyc, c + 1 + LAT);
        chk("load2_done_cnt", n_done - d0, 1);
        chk("load2_done_lag", done_cyc, edge_cyc + 1);
        chk("load2_opcode", opcode, 4'hA);
        chk("load2_instr", instr, 12'h53C);
        chk("load2_loading", loading, 0);

        // Bounce rejection (press becomes a high byte), then timeout
        e0 = n_edge; d0 = n_done;
`ifdef INSTR_LOADER_DEBOUNCE_EN
        data_in = 8'h66;
        c_last = cyc;
        for (int i = 0; i < 13; i++) begin
            btn = ~btn;
            c_last = cyc;
            tick(3);
        end
        tick(HOLD);
        btn = 1'b0;
        tick(HOLD);
`else
        press(8'h66, c_last);
`endif
        $display("bounce press edges=%0d", n_edge - e0);
        chk("bounce_edge_cnt", n_edge - e0, 1);
        chk("bounce_edge_cyc", edge_cyc, c_last + 1 + LAT);
        chk("bounce_loading", loading, 1);
        tick(TO + LAT + 10);
        $display("timeout loading_cycles=%0d", fall_cyc - rise_cyc);
        chk("timeout_len", fall_cyc - rise_cyc, TO);
        chk("timeout_loading", loading, 0);
        chk("timeout_no_done", n_done - d0, 0);
        chk("timeout_opcode", opcode, 4'hA);
        chk("timeout_instr", instr, 12'h53C);
`ifdef INSTR_LOADER_DEBOUNCE_EN
        e0 = n_edge;
        btn = 1'b1;
        tick(10);
        btn = 1'b0;
        tick(30);
        $display("glitch edges=%0d", n_edge - e0);
        chk("glitch_no_edge", n_edge - e0, 0);
        chk("glitch_loading", loading, 0);
`endif

        // Next press after timeout is a fresh high byte
        d0 = n_done;
        press(8'h5B, c);
        chk("post_to_loading", loading, 1);
        press(8'h7E, c);
        $display("reload opcode=%0h instr=%0h", opcode, instr);
        chk("post_to_done", n_done - d0, 1);
        chk("post_to_opcode", opcode, 4'h5);
        chk("post_to_instr", instr, 12'hB7E);

        // Second press lands exactly on to_cnt == TO-1
        d0 = n_done;
        press(8'h9F, c1);
        tick(TO - 2 * HOLD);
        press(8'h21, c2);
        $display("simul align=%0d opcode=%0h instr=%0h", edge_cyc - rise_cyc, opcode, instr);
        chk("simul_align", edge_cyc - rise_cyc, TO - 1);
        chk("simul_done", n_done - d0, 1);
        chk("simul_opcode", opcode, 4'h9);
        chk("simul_instr", instr, 12'hF21);
        chk("simul_loading", loading, 0);

        // Reset in the middle of a load
        press(8'hEE, c);
        chk("midrst_loading_pre", loading, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_opcode", opcode, 0);
        chk("midrst_instr", instr, 0);
        chk("midrst_loading", loading, 0);
        chk("midrst_btn_edge", btn_edge, 0);
        #2 rst_n = 1'b1;
        tick(2);
        d0 = n_done;
        press(8'h12, c);
        press(8'h34, c);
        $display("after reset opcode=%0h instr=%0h", opcode, instr);
        chk("midrst_done", n_done - d0, 1);
        chk("midrst_new_opcode", opcode, 4'h1);
        chk("midrst_new_instr", instr, 12'h234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Front-end stage that feeds `cpu_core`. It turns a raw push-button and an 8-bit switch bank into complete instructions for the core. The button is synchronised, debounced and edge-detected. The block then assembles two button-strobed bytes into `{opcode[3:0], instr[11:0]}` and pulses `inst_done` once the instruction is complete. It also forwards the debounced press pulse as `btn_edge` for the core's single-step use.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before the debounced button changes (≥2).
- `TIMEOUT_CYCLES`, default 4096: idle cycles after the high byte before the partial load is discarded.
  - 0 disables the timeout.
- `clk`  in  1  single clock; every register is on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `data_in`  in  8  switch bank; treated as quasi-static and sampled only in the `btn_edge` cycle.
- `btn`  in  1  raw, asynchronous, bouncing push-button (active-high).
- `opcode`  out  4  opcode of the last complete instruction.
- `instr`  out  12  operand field of the last complete instruction.
- `inst_done`  out  1  one-cycle pulse: `opcode`/`instr` were just updated.
- `btn_edge`  out  1  one-cycle pulse per debounced press.
- `loading`  out  1  high while the high byte is held and the low byte is awaited.

## Operation
- **Synchroniser:** two flops, reset 0, produce `btn_s`.
- **Debouncer:**
  - Counter `db_cnt`, width `$clog2(DEBOUNCE_CYCLES)+1`.
  - Cleared whenever `btn_s == btn_db`.
  - Incremented while they differ.
  - When it reaches `DEBOUNCE_CYCLES-1` with `btn_s` still different: `btn_db <= btn_s` and `db_cnt <= 0`.
  - A single-cycle glitch shorter than `DEBOUNCE_CYCLES` never changes `btn_db`.
- **Edge detector:** `btn_edge` is registered and equals `btn_db & ~btn_db_d`.
  - Only rising edges produce a pulse.
  - Release produces nothing.
- **FSM states:**
  - `IDLE`: on `btn_edge`, `hi_q <= data_in`, `to_cnt <= 0`, go to `HAVE_HI`.
  - `HAVE_HI` (`loading`=1):
    - On `btn_edge`: `{opcode, instr} <= {hi_q, data_in}`, `inst_done <= 1`, go to `IDLE`.
    - Otherwise `to_cnt` increments.
    - If `TIMEOUT_CYCLES != 0` and `to_cnt == TIMEOUT_CYCLES-1`, go to `IDLE` with `hi_q` discarded; outputs are unchanged and there is no pulse.
- **Atomic update:** `opcode` and `instr` change together, only in the cycle `inst_done` rises, and hold until the next complete load.
- **Byte split:**
  - First byte = `{opcode, instr[11:8]}`.
  - Second byte = `instr[7:0]`.
- **Simultaneous timeout and `btn_edge`:** the press wins; the instruction completes.
- **`btn_edge` routing:** forwarded regardless of FSM state, so the core sees every press. The core ignores it while not executing.
- **Reset mid-load:** asynchronous clear of every register.
  - Resets `hi_q`=0, `to_cnt`=0, the sync flops, `btn_db`, `btn_db_d` and `db_cnt`.
  - Outputs reset to `opcode`=0, `instr`=0, `inst_done`=0, `btn_edge`=0, `loading`=0, with the FSM in `IDLE`.
  - A partially loaded byte is lost.
  - A button held through reset release produces one `btn_edge` after debounce.

## Timing
- Let k be the first rising edge at which `btn`=1 is sampled, with `btn` held stable.
  - `btn_s` = 1 after edge k+1.
  - `btn_db` = 1 after edge k+1+`DEBOUNCE_CYCLES`.
  - `btn_edge` is high for exactly one cycle following edge k+2+`DEBOUNCE_CYCLES`.
- `data_in` is captured on the edge that ends the `btn_edge` cycle.
  - `inst_done`, the new `opcode`/`instr` and `loading` all change on that same edge.
  - So `inst_done` lags the second `btn_edge` by 1 cycle.
- Minimum press-to-press spacing equals 2·`DEBOUNCE_CYCLES` cycles: the release must also debounce.
- No back-pressure. `cpu_core` must tolerate a new `inst_done` at any time; the loader never waits on it.

## Configuration
- Macro `INSTR_LOADER_DEBOUNCE_EN`.
- **Defined:** the debouncer is built as described.
- **Undefined:**
  - `btn_db` = `btn_s` registered with no counter.
  - `DEBOUNCE_CYCLES` is ignored.
  - `btn_edge` latency is k+3.
  - Intended for simulation and clean-stimulus FPGA bring-up.

## Test plan
- **Reset defaults:** assert `rst_n`=0 mid-cycle, then release → all outputs 0 and `loading`=0 immediately (asynchronous).
- **Clean two-byte load:** press with `data_in`=0xA5, release, press with `data_in`=0x3C (`DEBOUNCE_CYCLES`=16).
  - Required: one `btn_edge` at k+18 per press.
  - Required: `opcode`=0xA, `instr`=0x53C, and a single-cycle `inst_done` one cycle after the second `btn_edge`.
- **Bounce rejection:** toggle `btn` every 3 cycles for 40 cycles, then hold high.
  - Required: exactly one `btn_edge`, 18 cycles after the last toggle.
  - Required: a 10-cycle glitch produces none.
- **Timeout:** `TIMEOUT_CYCLES`=64, one press, then no press.
  - Required: `loading` drops after 64 cycles; `opcode`/`instr` are unchanged and there is no `inst_done`.
  - Required: a next press is treated as a high byte.
- **Simultaneous timeout and press:** align the second `btn_edge` with `to_cnt`=63 → the instruction completes and `inst_done`=1.
- **Reset mid-load:** press once (`loading`=1), pulse `rst_n` low, press twice with 0x12 then 0x34.
  - Required: `opcode`=0x1, `instr`=0x234.
  - Required: the pre-reset byte never appears.
